// File: rtl/poly_sched_pkg.sv
// Shared types for the polynomial-multiplier scheduler: default polynomial
// geometry, the packed polynomial type and the scheduler state encoding.
package poly_sched_pkg;

   localparam int N_COEFF = 8;
   localparam int COEFF_W = 8;

   typedef logic [N_COEFF-1:0][COEFF_W-1:0] poly_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the requester
// after the last advanced one; the pointer moves only on the advance strobe.
module rr_arbiter #(
   parameter int N_REQ = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             advance,
   output logic [N_REQ-1:0] grant
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] next_ptr;
   logic [IDX_W-1:0] idx;
   logic             found;

   // next_ptr follows the winner so advancing moves priority just past it
   always_comb begin
      grant    = '0;
      next_ptr = ptr;
      idx      = '0;
      found    = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = IDX_W'((int'(ptr) + i) % N_REQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            next_ptr   = IDX_W'((int'(idx) + 1) % N_REQ);
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= next_ptr;
      end
   end

endmodule

// File: rtl/poly_mult_scheduler.sv
// Arbitrates N_REQ requesters onto one polynomial multiplier and routes the
// product back to the owner. Optional watchdog: define POLY_MULT_TIMEOUT_EN.
module poly_mult_scheduler #(
   parameter int N_COEFF     = poly_sched_pkg::N_COEFF,
   parameter int COEFF_W     = poly_sched_pkg::COEFF_W,
   parameter int N_REQ       = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [N_REQ-1:0]                        req_valid,
   output logic [N_REQ-1:0]                        req_ready,
   input  logic [N_REQ-1:0][N_COEFF-1:0][COEFF_W-1:0] req_a,
   input  logic [N_REQ-1:0][N_COEFF-1:0][COEFF_W-1:0] req_b,
   output logic [N_REQ-1:0]                        rsp_valid,
   input  logic [N_REQ-1:0]                        rsp_ready,
   output logic [N_COEFF-1:0][COEFF_W-1:0]         rsp_data,
   output logic                                    rsp_err,
   output logic                                    pm_start,
   output logic [N_COEFF-1:0][COEFF_W-1:0]         pm_as,
   output logic [N_COEFF-1:0][COEFF_W-1:0]         pm_bs,
   input  logic [N_COEFF-1:0][COEFF_W-1:0]         pm_cs,
   input  logic                                    pm_done,
   output poly_sched_pkg::state_t                  state_dbg
);

   typedef logic [N_COEFF-1:0][COEFF_W-1:0] poly_w_t;

   poly_sched_pkg::state_t state, state_nxt;
   logic [N_REQ-1:0] owner_q;
   logic [N_REQ-1:0] arb_req;
   logic [N_REQ-1:0] grant;
   logic             accept;
   logic             load_rsp;
   logic             load_err;
   logic             release_rsp;
   logic             wd_expired;
   poly_w_t          sel_a;
   poly_w_t          sel_b;

   // Handshakes: a request transfers on a cycle where req_valid[i] and
   // req_ready[i] are both high (only in IDLE, one winner); a response
   // transfers when rsp_valid[owner] and rsp_ready[owner] are both high, and
   // rsp_valid/rsp_data hold steady until then.

   // Outside IDLE the arbiter sees only the owner, so the advance in RESP
   // moves priority past the requester that was actually served.
   assign arb_req = (state == poly_sched_pkg::IDLE) ? req_valid : owner_q;

   rr_arbiter #(
      .N_REQ(N_REQ)
   ) u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (arb_req),
      .advance(release_rsp),
      .grant  (grant)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_a = req_a[i];
            sel_b = req_b[i];
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      load_rsp    = 1'b0;
      load_err    = 1'b0;
      release_rsp = 1'b0;
      unique case (state)
         poly_sched_pkg::IDLE: begin
            if (|req_valid) begin
               accept    = 1'b1;
               state_nxt = poly_sched_pkg::ISSUE;
            end
         end
         poly_sched_pkg::ISSUE: state_nxt = poly_sched_pkg::WAIT;
         poly_sched_pkg::WAIT: begin
            if (pm_done) begin
               load_rsp  = 1'b1;
               state_nxt = poly_sched_pkg::RESP;
            end else if (wd_expired) begin
               load_err  = 1'b1;
               state_nxt = poly_sched_pkg::RESP;
            end
         end
         poly_sched_pkg::RESP: begin
            if (|(rsp_ready & owner_q)) begin
               release_rsp = 1'b1;
               state_nxt   = poly_sched_pkg::IDLE;
            end
         end
         default: state_nxt = poly_sched_pkg::IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= poly_sched_pkg::IDLE;
         owner_q  <= '0;
         pm_as    <= '0;
         pm_bs    <= '0;
         rsp_data <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner_q <= grant;
            pm_as   <= sel_a;
            pm_bs   <= sel_b;
         end
         if (load_rsp) begin
            rsp_data <= pm_cs;
         end else if (load_err) begin
            rsp_data <= '0;
         end
      end
   end

`ifdef POLY_MULT_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wdog;

   // wdog equals the number of WAIT cycles already spent before this one
   assign wd_expired = (wdog == WD_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wdog    <= '0;
         rsp_err <= 1'b0;
      end else begin
         if (state == poly_sched_pkg::WAIT && state_nxt == poly_sched_pkg::WAIT) begin
            wdog <= wdog + 1'b1;
         end else begin
            wdog <= '0;
         end
         if (load_rsp) begin
            rsp_err <= 1'b0;
         end else if (load_err) begin
            rsp_err <= 1'b1;
         end
      end
   end
`else
   logic unused_timeout;

   assign wd_expired     = 1'b0;
   assign rsp_err        = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYC;
`endif

   assign req_ready = (state == poly_sched_pkg::IDLE && !reset) ? grant : '0;
   assign pm_start  = (state == poly_sched_pkg::ISSUE);
   assign rsp_valid = (state == poly_sched_pkg::RESP) ? owner_q : '0;
   assign state_dbg = state;

endmodule

// File: tb/tb_poly_mult_scheduler.sv
// Directed bench for poly_mult_scheduler: reset, arbitration, latency,
// backpressure, spurious strobes, watchdog (POLY_MULT_TIMEOUT_EN) and reset mid-job.
module tb_poly_mult_scheduler;
   import poly_sched_pkg::*;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [1:0]           req_valid;
   logic [1:0]           req_ready;
   logic [1:0][7:0][7:0] req_a;
   logic [1:0][7:0][7:0] req_b;
   logic [1:0]           rsp_valid;
   logic [1:0]           rsp_ready;
   poly_t                rsp_data;
   logic                 rsp_err;
   logic                 pm_start;
   poly_t                pm_as;
   poly_t                pm_bs;
   poly_t                pm_cs;
   logic                 pm_done;
   state_t               state_dbg;

   int checks   = 0;
   int failures = 0;

   poly_t a0, a1, b0, b1;

   poly_mult_scheduler #(
      .N_COEFF(8),
      .COEFF_W(8),
      .N_REQ(2),
      .TIMEOUT_CYC(16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a    (req_a),
      .req_b    (req_b),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data (rsp_data),
      .rsp_err  (rsp_err),
      .pm_start (pm_start),
      .pm_as    (pm_as),
      .pm_bs    (pm_bs),
      .pm_cs    (pm_cs),
      .pm_done  (pm_done),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   function automatic poly_t mk(input logic [7:0] c0, input logic [7:0] c1);
      poly_t p;
      p    = '0;
      p[0] = c0;
      p[1] = c1;
      return p;
   endfunction

   task automatic test_reset();
      reset     = 1'b1;
      req_valid = 2'b11;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
      checks++; if (pm_start !== 1'b0) begin failures++; $display("FAIL reset_pm_start: got %b want 0", pm_start); end
      checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
      checks++; if (rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
      checks++; if (pm_as !== '0 || pm_bs !== '0) begin failures++; $display("FAIL reset_operands: got %h/%h want 0/0", pm_as, pm_bs); end
      checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE); end
      req_valid = 2'b00;
      reset     = 1'b0;
   endtask

   task automatic test_contention();
      logic [1:0] exp;
      poly_t      cs;
      for (int j = 0; j < 3; j++) begin
         exp = (j == 1) ? 2'b10 : 2'b01;
         cs  = mk(8'h40 + 8'(j), 8'h01);
         @(negedge clk); rsp_ready = 2'b00; req_valid = 2'b11; #1;
         checks++; if (req_ready !== exp) begin failures++; $display("FAIL rr_grant job%0d: got %b want %b", j, req_ready, exp); end
         checks++; if ($countones(req_ready) != 1) begin failures++; $display("FAIL rr_onehot job%0d: got %b want one bit", j, req_ready); end
         @(negedge clk); #1;
         checks++; if (pm_start !== 1'b1) begin failures++; $display("FAIL rr_pm_start job%0d: got %b want 1", j, pm_start); end
         checks++; if (pm_as !== ((exp == 2'b01) ? a0 : a1) || pm_bs !== ((exp == 2'b01) ? b0 : b1)) begin
            failures++; $display("FAIL rr_operands job%0d: got %h/%h", j, pm_as, pm_bs);
         end
         checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rr_ready_issue job%0d: got %b want 00", j, req_ready); end
         @(negedge clk); pm_done = 1'b1; pm_cs = cs; #1;
         checks++; if (state_dbg !== WAIT) begin failures++; $display("FAIL rr_wait job%0d: got %0d want %0d", j, state_dbg, WAIT); end
         @(negedge clk); pm_done = 1'b0; pm_cs = '1; rsp_ready = 2'b11; #1;
         checks++; if (rsp_valid !== exp) begin failures++; $display("FAIL rr_rsp_valid job%0d: got %b want %b", j, rsp_valid, exp); end
         checks++; if (rsp_data !== cs) begin failures++; $display("FAIL rr_rsp_data job%0d: got %h want %h", j, rsp_data, cs); end
      end
      @(negedge clk); rsp_ready = 2'b00; req_valid = 2'b00; #1;
      checks++; if (state_dbg !== IDLE || rsp_valid !== 2'b00) begin
         failures++; $display("FAIL rr_end: got state %0d rsp_valid %b want IDLE/00", state_dbg, rsp_valid);
      end
   endtask

   task automatic test_single();
      @(negedge clk);
      req_a[0] = mk(8'd1, 8'd0); req_b[0] = mk(8'd1, 8'd0); req_valid = 2'b01; #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready: got %b want 01", req_ready); end
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         req_valid = 2'b00;
         pm_done   = (k == 7);
         pm_cs     = (k == 7) ? mk(8'd1, 8'd0) : mk(8'hEE, 8'hEE);
         rsp_ready = (k == 8) ? 2'b01 : 2'b00;
         #1;
         if (k == 1) begin
            checks++; if (pm_start !== 1'b1 || pm_as !== mk(8'd1, 8'd0)) begin
               failures++; $display("FAIL single_issue: got start %b as %h want 1/%h", pm_start, pm_as, mk(8'd1, 8'd0));
            end
         end
         if (k < 8) begin
            checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL single_early_rsp at +%0d: got %b want 00", k, rsp_valid); end
         end else begin
            checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); end
            checks++; if (rsp_data !== mk(8'd1, 8'd0)) begin failures++; $display("FAIL single_rsp_data: got %h want %h", rsp_data, mk(8'd1, 8'd0)); end
            checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL single_rsp_err: got %b want 0", rsp_err); end
         end
      end
      @(negedge clk); rsp_ready = 2'b00; #1;
      checks++; if (rsp_valid !== 2'b00 || state_dbg !== IDLE) begin
         failures++; $display("FAIL single_release: got %b state %0d want 00/IDLE", rsp_valid, state_dbg);
      end
   endtask

   task automatic test_backpressure();
      poly_t cb;
      cb = mk(8'h5A, 8'hA5);
      @(negedge clk); req_a[1] = a1; req_valid = 2'b10; #1;
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_ready: got %b want 10", req_ready); end
      @(negedge clk); req_valid = 2'b00; #1;
      @(negedge clk); pm_done = 1'b1; pm_cs = cb; #1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         pm_done   = (k == 3);
         pm_cs     = mk(8'(k), 8'(k));
         rsp_ready = 2'b01;
         req_valid = 2'b01;
         #1;
         checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL bp_rsp_valid cyc%0d: got %b want 10", k, rsp_valid); end
         checks++; if (rsp_data !== cb) begin failures++; $display("FAIL bp_rsp_data cyc%0d: got %h want %h", k, rsp_data, cb); end
         checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_req_ready cyc%0d: got %b want 00", k, req_ready); end
      end
      @(negedge clk); req_valid = 2'b00; rsp_ready = 2'b10; pm_done = 1'b0; #1;
      checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL bp_hold_last: got %b want 10", rsp_valid); end
      @(negedge clk); rsp_ready = 2'b00; #1;
      checks++; if (rsp_valid !== 2'b00 || state_dbg !== IDLE) begin
         failures++; $display("FAIL bp_release: got %b state %0d want 00/IDLE", rsp_valid, state_dbg);
      end
   endtask

   task automatic test_spurious();
      poly_t c;
      c = mk(8'h33, 8'h44);
      @(negedge clk); pm_done = 1'b1; req_valid = 2'b00; #1;
      @(negedge clk); #1;
      checks++; if (state_dbg !== IDLE || rsp_valid !== 2'b00) begin
         failures++; $display("FAIL spur_idle: got state %0d rsp_valid %b want IDLE/00", state_dbg, rsp_valid);
      end
      @(negedge clk); req_a[0] = a0; req_valid = 2'b01; #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL spur_accept: got %b want 01", req_ready); end
      @(negedge clk); req_valid = 2'b00; #1;
      checks++; if (state_dbg !== ISSUE) begin failures++; $display("FAIL spur_issue_state: got %0d want %0d", state_dbg, ISSUE); end
      @(negedge clk); pm_done = 1'b0; #1;
      checks++; if (state_dbg !== WAIT || rsp_valid !== 2'b00) begin
         failures++; $display("FAIL spur_after_issue: got state %0d rsp_valid %b want WAIT/00", state_dbg, rsp_valid);
      end
      repeat (3) begin
         @(negedge clk); #1;
         checks++; if (state_dbg !== WAIT) begin failures++; $display("FAIL spur_wait_hold: got %0d want %0d", state_dbg, WAIT); end
      end
      @(negedge clk); pm_done = 1'b1; pm_cs = c; #1;
      @(negedge clk); pm_done = 1'b0; rsp_ready = 2'b01; #1;
      checks++; if (rsp_valid !== 2'b01 || rsp_data !== c) begin
         failures++; $display("FAIL spur_rsp: got %b/%h want 01/%h", rsp_valid, rsp_data, c);
      end
      @(negedge clk); rsp_ready = 2'b00; #1;
   endtask

`ifdef POLY_MULT_TIMEOUT_EN
   task automatic test_timeout();
      @(negedge clk); req_valid = 2'b01; #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL to_accept: got %b want 01", req_ready); end
      @(negedge clk); req_valid = 2'b00; pm_cs = mk(8'hFF, 8'hFF); #1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk); #1;
         checks++; if (state_dbg !== WAIT || rsp_valid !== 2'b00) begin
            failures++; $display("FAIL to_wait cyc%0d: got state %0d rsp_valid %b want WAIT/00", k, state_dbg, rsp_valid);
         end
      end
      @(negedge clk); rsp_ready = 2'b01; #1;
      checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL to_rsp_valid: got %b want 01", rsp_valid); end
      checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL to_rsp_err: got %b want 1", rsp_err); end
      checks++; if (rsp_data !== '0) begin failures++; $display("FAIL to_rsp_data: got %h want 0", rsp_data); end
      @(negedge clk); rsp_ready = 2'b00; #1;
      checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL to_release: got %0d want %0d", state_dbg, IDLE); end
   endtask
`else
   task automatic test_wait_persist();
      poly_t c;
      c = mk(8'h77, 8'h01);
      @(negedge clk); req_valid = 2'b01; #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL persist_accept: got %b want 01", req_ready); end
      @(negedge clk); req_valid = 2'b00; #1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk); #1;
         checks++; if (state_dbg !== WAIT || rsp_valid !== 2'b00) begin
            failures++; $display("FAIL persist_wait cyc%0d: got state %0d rsp_valid %b want WAIT/00", k, state_dbg, rsp_valid);
         end
      end
      @(negedge clk); pm_done = 1'b1; pm_cs = c; #1;
      @(negedge clk); pm_done = 1'b0; rsp_ready = 2'b01; #1;
      checks++; if (rsp_valid !== 2'b01 || rsp_data !== c || rsp_err !== 1'b0) begin
         failures++; $display("FAIL persist_rsp: got %b/%h/%b want 01/%h/0", rsp_valid, rsp_data, rsp_err, c);
      end
      @(negedge clk); rsp_ready = 2'b00; #1;
   endtask
`endif

   task automatic test_reset_mid_wait();
      poly_t c;
      c = mk(8'h19, 8'h91);
      @(negedge clk); req_a[0] = a0; req_a[1] = a1; req_valid = 2'b11; #1;
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rmw_pre_grant: got %b want 10", req_ready); end
      @(negedge clk); req_valid = 2'b00; #1;
      @(negedge clk); #1;
      checks++; if (state_dbg !== WAIT) begin failures++; $display("FAIL rmw_in_wait: got %0d want %0d", state_dbg, WAIT); end
      @(negedge clk); #1;
      reset = 1'b1; #1;
      checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL rmw_state: got %0d want %0d", state_dbg, IDLE); end
      checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || pm_start !== 1'b0 || rsp_err !== 1'b0) begin
         failures++; $display("FAIL rmw_ctrl: got ready %b valid %b start %b err %b want all 0", req_ready, rsp_valid, pm_start, rsp_err);
      end
      checks++; if (rsp_data !== '0 || pm_as !== '0 || pm_bs !== '0) begin
         failures++; $display("FAIL rmw_data: got %h/%h/%h want 0", rsp_data, pm_as, pm_bs);
      end
      @(negedge clk); reset = 1'b0; pm_done = 1'b1; #1;
      @(negedge clk); pm_done = 1'b0; #1;
      checks++; if (rsp_valid !== 2'b00 || state_dbg !== IDLE) begin
         failures++; $display("FAIL rmw_abandon: got %b state %0d want 00/IDLE", rsp_valid, state_dbg);
      end
      @(negedge clk); req_valid = 2'b11; #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rmw_prio0: got %b want 01", req_ready); end
      @(negedge clk); req_valid = 2'b00; #1;
      @(negedge clk); pm_done = 1'b1; pm_cs = c; #1;
      @(negedge clk); pm_done = 1'b0; rsp_ready = 2'b11; #1;
      checks++; if (rsp_valid !== 2'b01 || rsp_data !== c) begin
         failures++; $display("FAIL rmw_next_rsp: got %b/%h want 01/%h", rsp_valid, rsp_data, c);
      end
      @(negedge clk); rsp_ready = 2'b00; #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not reach its summary");
      $fatal(1, "bench time limit expired");
   end

   initial begin
      a0 = mk(8'h11, 8'h12);
      a1 = mk(8'h21, 8'h22);
      b0 = mk(8'h03, 8'h00);
      b1 = mk(8'h05, 8'h00);
      reset     = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      pm_done   = 1'b0;
      pm_cs     = '0;
      req_a[0]  = a0;
      req_a[1]  = a1;
      req_b[0]  = b0;
      req_b[1]  = b1;

      test_reset();
      test_contention();
      test_single();
      test_backpressure();
      test_spurious();
`ifdef POLY_MULT_TIMEOUT_EN
      test_timeout();
`else
      test_wait_persist();
`endif
      test_reset_mid_wait();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/poly_mult_scheduler.md
POLY_MULT_SCHEDULER -- requirements
Module: poly_mult_scheduler

Interface
REQ-001 Parameter N_COEFF, default 8: coefficients per polynomial.
REQ-002 Parameter COEFF_W, default 8: bits per coefficient.
REQ-003 Parameter N_REQ, default 2: number of requester ports.
REQ-004 Parameter TIMEOUT_CYC, default 1024: watchdog limit in cycles; used only with the timeout feature.
REQ-005 clk  in  1  single clock; all state on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  N_REQ  per-requester operand-pair valid.
REQ-008 req_ready  out  N_REQ  per-requester accept; at most one bit high.
REQ-009 req_a, req_b  in  N_REQ x poly_t  operand polynomials per requester.
REQ-010 rsp_valid  out  N_REQ  result valid, routed to the owning requester.
REQ-011 rsp_ready  in  N_REQ  per-requester result accept.
REQ-012 rsp_data  out  poly_t  product polynomial, shared by all requesters.
REQ-013 rsp_err  out  1  watchdog expiry flag qualifying rsp_data.
REQ-014 pm_start  out  1  one-cycle start pulse to the polynomial multiplier.
REQ-015 pm_as, pm_bs  out  poly_t  registered operands to the multiplier.
REQ-016 pm_cs  in  poly_t  multiplier product.
REQ-017 pm_done  in  1  multiplier completion strobe.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-019 In IDLE with any req_valid high, the round-robin winner's req_ready SHALL be high that cycle, its operands SHALL be latched into pm_as/pm_bs, and the FSM SHALL go to ISSUE.
REQ-020 Round-robin: priority SHALL start at the requester after the last granted one; after reset requester 0 has priority.
REQ-021 req_ready SHALL be low in every state except IDLE; a winner's request is consumed in a single cycle.
REQ-022 In ISSUE, pm_start SHALL be high for exactly one cycle, and the FSM SHALL go to WAIT.
REQ-023 pm_done SHALL be sampled only in WAIT; a strobe in any other state SHALL be ignored.
REQ-024 In WAIT on pm_done, pm_cs SHALL be registered into rsp_data, rsp_err cleared, and the FSM SHALL go to RESP.
REQ-025 In RESP, rsp_valid[grant] SHALL be held high with rsp_data stable until rsp_ready[grant]; then the FSM SHALL go to IDLE and the priority pointer SHALL advance.
REQ-026 rsp_ready bits of non-owning requesters SHALL be ignored.
REQ-027 Minimum latency from request acceptance to rsp_valid SHALL be 3 cycles plus the multiplier latency.
REQ-028 pm_as/pm_bs SHALL hold their values from acceptance until the next acceptance.

Reset
REQ-029 On reset assertion, regardless of state, the FSM SHALL go to IDLE, and req_ready, rsp_valid, pm_start and rsp_err SHALL be 0.
REQ-030 On reset assertion, rsp_data, pm_as and pm_bs SHALL be 0, the priority pointer SHALL be 0 and the watchdog SHALL be 0.
REQ-031 A reset during WAIT SHALL abandon the job, and no response SHALL be produced for it.

Configuration
REQ-032 With POLY_MULT_TIMEOUT_EN defined, a watchdog SHALL count WAIT cycles; on reaching TIMEOUT_CYC without pm_done, the FSM SHALL go to RESP with rsp_err=1 and rsp_data all zero.
REQ-033 With POLY_MULT_TIMEOUT_EN undefined, no counter SHALL exist, rsp_err SHALL be tied 0, and WAIT SHALL persist until pm_done.

Structure
REQ-034 Package poly_sched_pkg SHALL hold N_COEFF, COEFF_W, typedef poly_t (packed [N_COEFF-1:0][COEFF_W-1:0]) and the state enum.
REQ-035 Arbitration SHALL be a sub-module rr_arbiter taking N_REQ requests plus an advance strobe, and returning a one-hot grant.

Verification
REQ-036 Single request: req_valid=01, a=b={1,0,...}, multiplier returns cs={1,0,...} after 5 cycles -> rsp_valid=01 at acceptance+8, rsp_data={1,0,...}.
REQ-037 Contention: req_valid=11 held for three jobs -> grants in the order 0,1,0, with exactly one req_ready bit per acceptance.
REQ-038 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=00 throughout.
REQ-039 Spurious pm_done in IDLE and ISSUE -> no state change and no rsp_valid.
REQ-040 With POLY_MULT_TIMEOUT_EN and TIMEOUT_CYC=16, pm_done never asserted -> rsp_valid with rsp_err=1 and rsp_data=0 after 16 WAIT cycles.
REQ-041 Reset asserted mid-WAIT -> all outputs 0 immediately, and the next request starts with requester 0 priority.
